mem_port_arbiter: RTL and testbench

Sequences a single-port unified instruction/data memory between the Fetch stage and the Memory stage of the 5-stage pipelined RISC-V core. It issues one memory transaction at a time and captures the response. It also generates the memory-induced stall and bubble signals that the hazard logic merges with its own load-use and branch controls. Data accesses win over fetches because they belong to an older instruction.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 78 +++++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the 5-stage RISC-V core: default address/data widths
// and the state encoding of the unified memory port arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // IDLE picks the next transaction, I_WAIT/D_WAIT hold an issued
    // instruction fetch or data access until the memory acknowledges it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Holds the most recently fetched instruction word for the Decode stage, along
// with its valid flag and the squash flag that marks an in-flight fetch as dead
// after a taken branch/jump.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   startFetch_i    arbiter is issuing a new fetch this cycle
//   inFetch_i       arbiter is waiting on an instruction fetch
//   fetchAck_i      memory acknowledged the outstanding instruction fetch
//   rdata_i         memory read data
//   holdF_i         hazard unit is stalling F, keep the word
//   redirect_i      taken branch/jump in E
//   stallMemM_i     data access still pending, D is frozen
//   iValid_o        instr_o holds an unconsumed instruction
//   instr_o         buffered instruction word
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DATA_WIDTH = riscv_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  startFetch_i,
    input  logic                  inFetch_i,
    input  logic                  fetchAck_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  holdF_i,
    input  logic                  redirect_i,
    input  logic                  stallMemM_i,
    output logic                  iValid_o,
    output logic [DATA_WIDTH-1:0] instr_o
);
    import riscv_pkg::*;

    logic                  iValid_q, iValid_d;
    logic                  squash_q, squash_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    // A redirect kills both the buffered word and any response still in
    // flight; a response arriving in the same cycle as the redirect is
    // dropped too. The word is consumed once D can advance.
    always_comb begin
        iValid_d = iValid_q;
        squash_d = squash_q;
        instr_d  = instr_q;

        if (startFetch_i) begin
            squash_d = 1'b0;
        end else if (inFetch_i && redirect_i) begin
            squash_d = 1'b1;
        end

        if (redirect_i) begin
            iValid_d = 1'b0;
        end else if (fetchAck_i && !squash_q) begin
            instr_d  = rdata_i;
            iValid_d = 1'b1;
        end else if (iValid_q && !holdF_i && !stallMemM_i) begin
            iValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iValid_q <= 1'b0;
            squash_q <= 1'b0;
            instr_q  <= '0;
        end else begin
            iValid_q <= iValid_d;
            squash_q <= squash_d;
            instr_q  <= instr_d;
        end
    end

    assign iValid_o = iValid_q;
    assign instr_o  = instr_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the Fetch and Memory stages.
// One transaction is outstanding at a time; data accesses win over fetches
// because they belong to an older instruction. Generates the memory stall
// signals that the hazard unit merges into its own stall/flush controls.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   PC_F, HoldF, Redirect_E    fetch address, F stall from hazard unit, branch
//   MemRead_M, MemWrite_M      data access request from M
//   ALUResult_M, WriteData_M   data address and store data
//   Instr_F, ReadData_M        fetched instruction, load data
//   StallMem_F, StallMem_M     fetch / data access not yet complete
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = riscv_pkg::DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = riscv_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] PC_F,
    input  logic                  HoldF,
    input  logic                  Redirect_E,
    input  logic                  MemRead_M,
    input  logic                  MemWrite_M,
    input  logic [ADDR_WIDTH-1:0] ALUResult_M,
    input  logic [DATA_WIDTH-1:0] WriteData_M,
    output logic [DATA_WIDTH-1:0] Instr_F,
    output logic [DATA_WIDTH-1:0] ReadData_M,
    output logic                  StallMem_F,
    output logic                  StallMem_M,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    import riscv_pkg::*;

    arb_state_e            state_q, state_d;
    logic                  dataReq;
    logic                  startData;
    logic                  startFetch;
    logic                  iValid;
    logic                  dDone_q, dDone_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    assign dataReq = MemRead_M | MemWrite_M;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // dDone_q marks the single cycle in which M sees its access complete, so
    // the same still-asserted request is not issued a second time.
    always_comb begin
        state_d    = state_q;
        startData  = 1'b0;
        startFetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (dataReq && !dDone_q) begin
                    startData = 1'b1;
                    state_d   = D_WAIT;
                end else if (!iValid) begin
                    startFetch = 1'b1;
                    state_d    = I_WAIT;
                end
            end
            I_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            D_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory port is fed only from these latched copies, so pipeline
    // inputs changing mid-transaction never disturb an issued access.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        dDone_d = (state_q == D_WAIT) && mem_ack;
        if (startData) begin
            addr_d  = ALUResult_M;
            wdata_d = WriteData_M;
            we_d    = MemWrite_M;
        end else if (startFetch) begin
            addr_d  = PC_F;
            we_d    = 1'b0;
        end
        if ((state_q == D_WAIT) && mem_ack && !we_q) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            dDone_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            dDone_q <= dDone_d;
        end
    end

    always_comb begin
        mem_req    = (state_q != IDLE);
        mem_we     = (state_q == D_WAIT) && we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        ReadData_M = rdata_q;
        StallMem_M = dataReq && !dDone_q;
        StallMem_F = !iValid || StallMem_M;
    end

    fetch_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .startFetch_i (startFetch),
        .inFetch_i    (state_q == I_WAIT),
        .fetchAck_i   ((state_q == I_WAIT) && mem_ack),
        .rdata_i      (mem_rdata),
        .holdF_i      (HoldF),
        .redirect_i   (Redirect_E),
        .stallMemM_i  (StallMem_M),
        .iValid_o     (iValid),
        .instr_o      (Instr_F)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed vector table, directed corner sequences and randomized pipeline
// traffic for mem_port_arbiter, with a transaction-level reference of the
// memory port and an emulated memory held in an associative array.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_F;
    logic        HoldF;
    logic        Redirect_E;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] Instr_F;
    logic [31:0] ReadData_M;
    logic        StallMem_F;
    logic        StallMem_M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_F        (PC_F),
        .HoldF       (HoldF),
        .Redirect_E  (Redirect_E),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .Instr_F     (Instr_F),
        .ReadData_M  (ReadData_M),
        .StallMem_F  (StallMem_F),
        .StallMem_M  (StallMem_M),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rstN;
        logic [31:0] pc;
        logic        holdF;
        logic        memRead;
        logic        memWrite;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        expReq;
        logic        expWe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic        expStallF;
        logic        expStallM;
        logic [31:0] expInstr;
        logic [31:0] expRead;
    } vec_t;

    typedef struct {
        bit          isFetch;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } txn_t;

    vec_t        vecs[$];
    txn_t        pend[$];
    logic [31:0] memArr [logic [31:0]];

    int          checks;
    int          errors;
    int          cycle;
    bit          mIValid;
    bit          mSquash;
    bit          mDDone;
    logic [31:0] mInstr;
    logic [31:0] mRead;
    logic [31:0] mLastAddr;
    logic [31:0] mLastWdata;
    int          waitCnt;
    int          curDelay;
    int          fixedDelay;
    bit          lastStallM;
    bit          lastStallF;
    bit          watchBad;
    int          sawBad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n       = v.rstN;
        PC_F        = v.pc;
        HoldF       = v.holdF;
        Redirect_E  = 1'b0;
        MemRead_M   = v.memRead;
        MemWrite_M  = v.memWrite;
        ALUResult_M = v.alu;
        WriteData_M = v.wdata;
        mem_ack     = v.ack;
        mem_rdata   = v.rdata;
    endtask

    task automatic setIdle();
        PC_F        = 32'h0;
        HoldF       = 1'b0;
        Redirect_E  = 1'b0;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        ALUResult_M = 32'h0;
        WriteData_M = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    function automatic logic [31:0] memLookup(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic modelClear();
        pend.delete();
        mIValid    = 1'b0;
        mSquash    = 1'b0;
        mDDone     = 1'b0;
        mInstr     = 32'h0;
        mRead      = 32'h0;
        mLastAddr  = 32'h0;
        mLastWdata = 32'h0;
        waitCnt    = 0;
        curDelay   = 0;
        lastStallM = 1'b0;
        lastStallF = 1'b1;
    endtask

    task automatic modelReset();
        rst_n = 1'b0;
        setIdle();
        @(negedge clk);
        cycle++;
        modelClear();
        rst_n = 1'b1;
    endtask

    task automatic issue(input txn_t t);
        pend.push_back(t);
        mLastAddr = t.addr;
        if (!t.isFetch) mLastWdata = t.wdata;
        waitCnt  = 0;
        curDelay = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
    endtask

    // One clock cycle: the emulated memory answers the outstanding
    // transaction, outputs are compared against the reference, and the
    // reference advances as the active edge would.
    task automatic modelStep();
        bit          busy;
        bit          ack;
        bit          stallM;
        bit          stallF;
        bit          nIValid;
        bit          nSquash;
        bit          nDDone;
        logic [31:0] rd;
        txn_t        cur;
        txn_t        t;
        cur  = '{1'b0, 32'h0, 1'b0, 32'h0};
        busy = (pend.size() != 0);
        ack  = 1'b0;
        rd   = $urandom;
        if (busy) begin
            cur = pend[0];
            ack = (waitCnt >= curDelay);
            if (ack) rd = memLookup(cur.addr);
        end
        mem_ack   = ack;
        mem_rdata = rd;
        #1;
        stallM = (MemRead_M || MemWrite_M) && !mDDone;
        stallF = !mIValid || stallM;
        checkOutput("mem_req",    32'(mem_req),    32'(busy));
        checkOutput("mem_we",     32'(mem_we),     32'(busy && !cur.isFetch && cur.we));
        checkOutput("mem_addr",   mem_addr,        mLastAddr);
        checkOutput("mem_wdata",  mem_wdata,       mLastWdata);
        checkOutput("StallMem_M", 32'(StallMem_M), 32'(stallM));
        checkOutput("StallMem_F", 32'(StallMem_F), 32'(stallF));
        checkOutput("Instr_F",    Instr_F,         mInstr);
        checkOutput("ReadData_M", ReadData_M,      mRead);
        if (watchBad && !StallMem_F && Instr_F == 32'hFFFF_FFFF) sawBad++;

        if (!rst_n) begin
            modelClear();
        end else begin
            nIValid = mIValid;
            nSquash = mSquash;
            nDDone  = 1'b0;
            if (busy) begin
                if (Redirect_E && cur.isFetch) nSquash = 1'b1;
                if (ack) begin
                    void'(pend.pop_front());
                    if (cur.isFetch) begin
                        if (!mSquash && !Redirect_E) begin
                            mInstr  = rd;
                            nIValid = 1'b1;
                        end
                    end else begin
                        nDDone = 1'b1;
                        if (cur.we) memArr[cur.addr] = cur.wdata;
                        else        mRead = rd;
                    end
                end else begin
                    waitCnt++;
                end
            end else if ((MemRead_M || MemWrite_M) && !mDDone) begin
                t = '{1'b0, ALUResult_M, MemWrite_M, WriteData_M};
                issue(t);
            end else if (!mIValid) begin
                t = '{1'b1, PC_F, 1'b0, 32'h0};
                issue(t);
                nSquash = 1'b0;
            end
            if (Redirect_E || (mIValid && !HoldF && !stallM)) nIValid = 1'b0;
            mIValid    = nIValid;
            mSquash    = nSquash;
            mDDone     = nDDone;
            lastStallM = stallM;
            lastStallF = stallF;
        end
        @(negedge clk);
        cycle++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit reqSeen;
        int r;
        checks     = 0;
        errors     = 0;
        cycle      = 0;
        fixedDelay = -1;
        watchBad   = 1'b0;
        sawBad     = 0;
        modelClear();

        // Reset, fetch from 0 acked at once, 4-cycle-stall load, then a store
        // and a fetch requested together with the store going first.
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h00500093, 1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h00500093, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b1, 32'h00500093, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b1, 32'h00500093, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b1, 32'h00500093, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h00000013, 1'b1, 1'b0, 32'h4,   32'h0,        1'b1, 1'b0, 32'h00500093, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h4,   32'h0,        1'b0, 1'b0, 32'h00000013, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4,   32'h0,        1'b1, 1'b1, 32'h00000013, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 32'h104, 32'h12345678, 1'b1, 1'b1, 32'h00000013, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 32'h104, 32'h12345678, 1'b1, 1'b0, 32'h00000013, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h00208233, 1'b1, 1'b0, 32'h8,   32'h12345678, 1'b1, 1'b0, 32'h00000013, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h8,   32'h12345678, 1'b0, 1'b0, 32'h00208233, 32'hDEADBEEF});

        rst_n = 1'b0;
        setIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput("vec.mem_req",    32'(mem_req),    32'(vecs[i].expReq));
            checkOutput("vec.mem_we",     32'(mem_we),     32'(vecs[i].expWe));
            checkOutput("vec.mem_addr",   mem_addr,        vecs[i].expAddr);
            checkOutput("vec.mem_wdata",  mem_wdata,       vecs[i].expWdata);
            checkOutput("vec.StallMem_F", 32'(StallMem_F), 32'(vecs[i].expStallF));
            checkOutput("vec.StallMem_M", 32'(StallMem_M), 32'(vecs[i].expStallM));
            checkOutput("vec.Instr_F",    Instr_F,         vecs[i].expInstr);
            checkOutput("vec.ReadData_M", ReadData_M,      vecs[i].expRead);
            @(negedge clk);
            cycle++;
        end

        // Redirect while a fetch of 0x200 (holding 0xFFFFFFFF) is waiting.
        modelReset();
        memArr[32'h200] = 32'hFFFF_FFFF;
        memArr[32'h300] = 32'h0010_0113;
        fixedDelay = 2;
        watchBad   = 1'b1;
        PC_F = 32'h200;
        modelStep();
        Redirect_E = 1'b1;
        modelStep();
        Redirect_E = 1'b0;
        PC_F = 32'h300;
        modelStep();
        fixedDelay = 0;
        modelStep();
        modelStep();
        checkOutput("redirReq",  32'(mem_req), 32'd1);
        checkOutput("redirAddr", mem_addr,     32'h300);
        modelStep();
        checkOutput("redirWord",   Instr_F,         32'h0010_0113);
        checkOutput("redirStallF", 32'(StallMem_F), 32'd0);
        modelStep();
        watchBad = 1'b0;
        checkOutput("redirDropped", 32'(sawBad), 32'd0);

        // HoldF keeps a fetched word for three cycles with no new request.
        modelReset();
        fixedDelay = 0;
        PC_F = 32'h40;
        modelStep();
        modelStep();
        HoldF   = 1'b1;
        reqSeen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("holdInstr", Instr_F, memLookup(32'h40));
            reqSeen |= mem_req;
            modelStep();
        end
        HoldF = 1'b0;
        reqSeen |= mem_req;
        checkOutput("holdNoReq", 32'(reqSeen), 32'd0);
        modelStep();
        PC_F = 32'h44;
        modelStep();
        checkOutput("holdNextReq",  32'(mem_req), 32'd1);
        checkOutput("holdNextAddr", mem_addr,     32'h44);
        modelStep();

        // Reset asserted while a load is waiting for its acknowledge.
        modelReset();
        fixedDelay  = 5;
        MemRead_M   = 1'b1;
        ALUResult_M = 32'h180;
        modelStep();
        modelStep();
        modelStep();
        rst_n     = 1'b0;
        MemRead_M = 1'b0;
        modelStep();
        rst_n = 1'b1;
        #1;
        checkOutput("rstReq",    32'(mem_req),    32'd0);
        checkOutput("rstStallM", 32'(StallMem_M), 32'd0);
        checkOutput("rstState",  32'(dut.state_q == riscv_pkg::IDLE), 32'd1);
        fixedDelay = -1;
        modelStep();
        modelStep();

        // Randomized pipeline traffic: M and F advance only when not stalled.
        modelReset();
        fixedDelay = -1;
        for (int c = 0; c < 400; c++) begin
            if (Redirect_E) PC_F = 32'($urandom_range(0, 31) * 4);
            else if (!lastStallF && !HoldF) PC_F = PC_F + 32'd4;
            if (!lastStallM) begin
                r           = int'($urandom_range(0, 9));
                MemRead_M   = (r < 3);
                MemWrite_M  = (r >= 3) && (r < 6);
                ALUResult_M = 32'h100 + 32'($urandom_range(0, 7) * 4);
                WriteData_M = $urandom;
            end
            HoldF      = ($urandom_range(0, 4) == 0);
            Redirect_E = ($urandom_range(0, 9) == 0);
            modelStep();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
